// File: rtl/xsim_dma_client_arbiter.sv
// Round-robin arbiter sharing one DMA read/write port among NCLIENTS requesters.
// An owner FIFO records who issued each in-flight read so responses return in issue order.
module xsim_dma_client_arbiter #(
  parameter int NCLIENTS    = 4,
  parameter int OWNER_DEPTH = 4
) (
  input  logic                          CLK,
  input  logic                          RST_N,
  input  logic [NCLIENTS-1:0]           cli_req_valid,
  input  logic [NCLIENTS-1:0]           cli_req_write,
  input  logic [32*NCLIENTS-1:0]        cli_req_handle,
  input  logic [32*NCLIENTS-1:0]        cli_req_addr,
  input  logic [32*NCLIENTS-1:0]        cli_req_data,
  input  logic [4*NCLIENTS-1:0]         cli_req_be,
  output logic [NCLIENTS-1:0]           cli_req_ready,
  output logic [NCLIENTS-1:0]           cli_rsp_valid,
  output logic [31:0]                   cli_rsp_data,
  input  logic [NCLIENTS-1:0]           cli_rsp_ready,
  input  logic                          dma_rdy_readrequest,
  output logic                          dma_en_readrequest,
  output logic [31:0]                   dma_readrequest_handle,
  output logic [31:0]                   dma_readrequest_addr,
  input  logic                          dma_rdy_readresponse,
  input  logic [31:0]                   dma_readresponse_data,
  output logic                          dma_en_readresponse,
  output logic                          dma_en_write32,
  output logic [31:0]                   dma_write32_handle,
  output logic [31:0]                   dma_write32_addr,
  output logic [31:0]                   dma_write32_data,
  output logic [3:0]                    dma_write32_byteenable,
  output logic [$clog2(OWNER_DEPTH+1)-1:0] reads_outstanding
);

  localparam int IW = $clog2(NCLIENTS);
  localparam int PW = (OWNER_DEPTH > 1) ? $clog2(OWNER_DEPTH) : 1;
  localparam int CW = $clog2(OWNER_DEPTH + 1);

  logic [IW-1:0]       rr_ptr;
  logic [IW-1:0]       winner;
  logic [IW-1:0]       head;
  logic [IW-1:0]       owner_fifo [OWNER_DEPTH];
  logic [PW-1:0]       wr_ptr;
  logic [PW-1:0]       rd_ptr;
  logic [CW-1:0]       count;
  logic [NCLIENTS-1:0] eligible;
  logic                fifo_full;
  logic                found;
  logic                grant;
  logic                win_write;
  logic                rsp_avail;
  logic                push;
  logic                pop;
  int                  idx;

  // Full FIFO blocks reads using the registered count, so a same-cycle pop never frees a slot early.
  always_comb begin
    fifo_full = (count == CW'(OWNER_DEPTH));
    eligible  = '0;
    found     = 1'b0;
    winner    = '0;
    idx       = 0;
    for (int i = 0; i < NCLIENTS; i++) begin
      eligible[i] = cli_req_valid[i] &
                    (cli_req_write[i] | (dma_rdy_readrequest & ~fifo_full));
    end
    for (int k = 0; k < NCLIENTS; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NCLIENTS) idx = idx - NCLIENTS;
      if (!found && eligible[IW'(idx)]) begin
        found  = 1'b1;
        winner = IW'(idx);
      end
    end
  end

  always_comb begin
    grant                  = found & RST_N;
    win_write              = cli_req_write[winner];
    cli_req_ready          = grant ? (NCLIENTS'(1) << winner) : '0;
    dma_en_readrequest     = grant & ~win_write;
    dma_en_write32         = grant & win_write;
    dma_readrequest_handle = '0;
    dma_readrequest_addr   = '0;
    dma_write32_handle     = '0;
    dma_write32_addr       = '0;
    dma_write32_data       = '0;
    dma_write32_byteenable = '0;
    if (dma_en_readrequest) begin
      dma_readrequest_handle = cli_req_handle[32*int'(winner) +: 32];
      dma_readrequest_addr   = cli_req_addr[32*int'(winner) +: 32];
    end
    if (dma_en_write32) begin
      dma_write32_handle     = cli_req_handle[32*int'(winner) +: 32];
      dma_write32_addr       = cli_req_addr[32*int'(winner) +: 32];
      dma_write32_data       = cli_req_data[32*int'(winner) +: 32];
      dma_write32_byteenable = cli_req_be[4*int'(winner) +: 4];
    end
  end

  // Response path depends only on FIFO state and response-side inputs, never on the grant.
  always_comb begin
    head                = owner_fifo[rd_ptr];
    rsp_avail           = RST_N & (count != '0) & dma_rdy_readresponse;
    cli_rsp_valid       = rsp_avail ? (NCLIENTS'(1) << head) : '0;
    cli_rsp_data        = rsp_avail ? dma_readresponse_data : '0;
    dma_en_readresponse = rsp_avail & cli_rsp_ready[head];
    push                = dma_en_readrequest;
    pop                 = dma_en_readresponse;
    reads_outstanding   = count;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rr_ptr <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < OWNER_DEPTH; i++) owner_fifo[i] <= '0;
    end else begin
      if (grant) begin
        rr_ptr <= (int'(winner) == NCLIENTS - 1) ? '0 : winner + IW'(1);
      end
      if (push) begin
        owner_fifo[wr_ptr] <= winner;
        wr_ptr <= (int'(wr_ptr) == OWNER_DEPTH - 1) ? '0 : wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= (int'(rd_ptr) == OWNER_DEPTH - 1) ? '0 : rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_xsim_dma_client_arbiter.sv
// Directed bench for xsim_dma_client_arbiter: grant order, owner FIFO routing,
// backpressure, FIFO-full behaviour and asynchronous reset.
module tb_xsim_dma_client_arbiter;

  localparam int N = 4;
  localparam int D = 4;

  logic            CLK;
  logic            RST_N;
  logic [N-1:0]    cli_req_valid;
  logic [N-1:0]    cli_req_write;
  logic [32*N-1:0] cli_req_handle;
  logic [32*N-1:0] cli_req_addr;
  logic [32*N-1:0] cli_req_data;
  logic [4*N-1:0]  cli_req_be;
  logic [N-1:0]    cli_req_ready;
  logic [N-1:0]    cli_rsp_valid;
  logic [31:0]     cli_rsp_data;
  logic [N-1:0]    cli_rsp_ready;
  logic            dma_rdy_readrequest;
  logic            dma_en_readrequest;
  logic [31:0]     dma_readrequest_handle;
  logic [31:0]     dma_readrequest_addr;
  logic            dma_rdy_readresponse;
  logic [31:0]     dma_readresponse_data;
  logic            dma_en_readresponse;
  logic            dma_en_write32;
  logic [31:0]     dma_write32_handle;
  logic [31:0]     dma_write32_addr;
  logic [31:0]     dma_write32_data;
  logic [3:0]      dma_write32_byteenable;
  logic [2:0]      reads_outstanding;

  int checks = 0;
  int errors = 0;

  xsim_dma_client_arbiter #(.NCLIENTS(N), .OWNER_DEPTH(D)) dut (
    .CLK                    (CLK),
    .RST_N                  (RST_N),
    .cli_req_valid          (cli_req_valid),
    .cli_req_write          (cli_req_write),
    .cli_req_handle         (cli_req_handle),
    .cli_req_addr           (cli_req_addr),
    .cli_req_data           (cli_req_data),
    .cli_req_be             (cli_req_be),
    .cli_req_ready          (cli_req_ready),
    .cli_rsp_valid          (cli_rsp_valid),
    .cli_rsp_data           (cli_rsp_data),
    .cli_rsp_ready          (cli_rsp_ready),
    .dma_rdy_readrequest    (dma_rdy_readrequest),
    .dma_en_readrequest     (dma_en_readrequest),
    .dma_readrequest_handle (dma_readrequest_handle),
    .dma_readrequest_addr   (dma_readrequest_addr),
    .dma_rdy_readresponse   (dma_rdy_readresponse),
    .dma_readresponse_data  (dma_readresponse_data),
    .dma_en_readresponse    (dma_en_readresponse),
    .dma_en_write32         (dma_en_write32),
    .dma_write32_handle     (dma_write32_handle),
    .dma_write32_addr       (dma_write32_addr),
    .dma_write32_data       (dma_write32_data),
    .dma_write32_byteenable (dma_write32_byteenable),
    .reads_outstanding      (reads_outstanding)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    RST_N                 = 1'b0;
    cli_req_valid         = '1;
    cli_req_write         = '0;
    cli_rsp_ready         = '0;
    dma_rdy_readrequest   = 1'b1;
    dma_rdy_readresponse  = 1'b1;
    dma_readresponse_data = 32'h1234_5678;
    for (int i = 0; i < N; i++) begin
      cli_req_handle[32*i +: 32] = 32'hA0 + i;
      cli_req_addr[32*i +: 32]   = 32'h1000 + 32'h10 * i;
      cli_req_data[32*i +: 32]   = 32'hDEAD_BEEF;
      cli_req_be[4*i +: 4]       = 4'b0011;
    end

    // Reset: everything quiet even with requests pending
    #3;
    chk("rst_ready", {28'd0, cli_req_ready}, 32'd0);
    chk("rst_en_rr", {31'd0, dma_en_readrequest}, 32'd0);
    chk("rst_rsp_valid", {28'd0, cli_rsp_valid}, 32'd0);
    chk("rst_outstanding", {29'd0, reads_outstanding}, 32'd0);
    @(posedge CLK);
    #1;
    dma_rdy_readresponse = 1'b0;
    RST_N = 1'b1;

    // All clients read continuously: grants 0,1,2,3 then FIFO full
    for (int k = 0; k < 4; k++) begin
      settle();
      chk("rr_grant", {28'd0, cli_req_ready}, 32'd1 << k);
      chk("rr_en", {31'd0, dma_en_readrequest}, 32'd1);
      chk("rr_addr", dma_readrequest_addr, 32'h1000 + 32'h10 * k);
      chk("rr_handle", dma_readrequest_handle, 32'hA0 + k);
      chk("rr_count", {29'd0, reads_outstanding}, k);
      cyc();
    end
    settle();
    chk("full_ready", {28'd0, cli_req_ready}, 32'd0);
    chk("full_en", {31'd0, dma_en_readrequest}, 32'd0);
    chk("full_addr", dma_readrequest_addr, 32'd0);
    chk("full_count", {29'd0, reads_outstanding}, 32'd4);

    // Writes still flow while the owner FIFO is full
    cli_req_write = '1;
    settle();
    chk("wr_grant0", {28'd0, cli_req_ready}, 32'b0001);
    chk("wr_en", {31'd0, dma_en_write32}, 32'd1);
    chk("wr_en_rr", {31'd0, dma_en_readrequest}, 32'd0);
    chk("wr_data", dma_write32_data, 32'hDEAD_BEEF);
    chk("wr_be", {28'd0, dma_write32_byteenable}, 32'b0011);
    chk("wr_addr0", dma_write32_addr, 32'h1000);
    cyc();
    settle();
    chk("wr_grant1", {28'd0, cli_req_ready}, 32'b0010);
    chk("wr_addr1", dma_write32_addr, 32'h1010);
    chk("wr_count", {29'd0, reads_outstanding}, 32'd4);
    cyc();

    // Drain in issue order; pop in same cycle does not unblock a read
    cli_req_valid         = 4'b0001;
    cli_req_write         = '0;
    dma_rdy_readresponse  = 1'b1;
    cli_rsp_ready         = '1;
    dma_readresponse_data = 32'h5000_0000;
    settle();
    chk("pop_full_block", {28'd0, cli_req_ready}, 32'd0);
    chk("rsp_valid0", {28'd0, cli_rsp_valid}, 32'b0001);
    chk("rsp_data0", cli_rsp_data, 32'h5000_0000);
    chk("rsp_en0", {31'd0, dma_en_readresponse}, 32'd1);
    cyc();
    cli_req_valid         = '0;
    dma_readresponse_data = 32'h5000_0001;
    settle();
    chk("rsp_valid1", {28'd0, cli_rsp_valid}, 32'b0010);
    chk("rsp_count1", {29'd0, reads_outstanding}, 32'd3);
    cyc();
    cli_rsp_ready         = 4'b1011;
    dma_readresponse_data = 32'h5000_0002;
    for (int k = 0; k < 5; k++) begin
      settle();
      chk("bp_en", {31'd0, dma_en_readresponse}, 32'd0);
      chk("bp_valid", {28'd0, cli_rsp_valid}, 32'b0100);
      chk("bp_data", cli_rsp_data, 32'h5000_0002);
      chk("bp_count", {29'd0, reads_outstanding}, 32'd2);
      cyc();
    end
    cli_rsp_ready = '1;
    settle();
    chk("bp_release", {31'd0, dma_en_readresponse}, 32'd1);
    cyc();
    dma_readresponse_data = 32'h5000_0003;
    settle();
    chk("rsp_valid3", {28'd0, cli_rsp_valid}, 32'b1000);
    chk("rsp_count3", {29'd0, reads_outstanding}, 32'd1);
    cyc();
    settle();
    chk("drain_count", {29'd0, reads_outstanding}, 32'd0);
    chk("stray_valid", {28'd0, cli_rsp_valid}, 32'd0);
    chk("stray_en", {31'd0, dma_en_readresponse}, 32'd0);
    chk("stray_data", cli_rsp_data, 32'd0);
    dma_rdy_readresponse = 1'b0;

    // Client1 read 0x100 then client3 read 0x200; responses return in that order
    cli_req_addr[32*1 +: 32] = 32'h100;
    cli_req_addr[32*3 +: 32] = 32'h200;
    cli_req_valid = 4'b0010;
    settle();
    chk("t2_grant1", {28'd0, cli_req_ready}, 32'b0010);
    chk("t2_addr1", dma_readrequest_addr, 32'h100);
    cyc();
    cli_req_valid = 4'b1000;
    settle();
    chk("t2_grant3", {28'd0, cli_req_ready}, 32'b1000);
    chk("t2_addr3", dma_readrequest_addr, 32'h200);
    cyc();
    cli_req_valid = '0;
    settle();
    chk("t2_count2", {29'd0, reads_outstanding}, 32'd2);
    dma_rdy_readresponse  = 1'b1;
    dma_readresponse_data = 32'hCAFE_0001;
    settle();
    chk("t2_rsp1", {28'd0, cli_rsp_valid}, 32'b0010);
    chk("t2_data1", cli_rsp_data, 32'hCAFE_0001);
    cyc();
    dma_readresponse_data = 32'hCAFE_0003;
    settle();
    chk("t2_rsp3", {28'd0, cli_rsp_valid}, 32'b1000);
    chk("t2_data3", cli_rsp_data, 32'hCAFE_0003);
    chk("t2_count1", {29'd0, reads_outstanding}, 32'd1);
    cyc();
    dma_rdy_readresponse = 1'b0;
    settle();
    chk("t2_count0", {29'd0, reads_outstanding}, 32'd0);

    // Read blocked by DMA not ready; write from client1 wins, rr_ptr moves to 2
    dma_rdy_readrequest = 1'b0;
    cli_req_valid = 4'b0011;
    cli_req_write = 4'b0010;
    settle();
    chk("t5_grant", {28'd0, cli_req_ready}, 32'b0010);
    chk("t5_en_wr", {31'd0, dma_en_write32}, 32'd1);
    chk("t5_en_rr", {31'd0, dma_en_readrequest}, 32'd0);
    cyc();
    dma_rdy_readrequest = 1'b1;
    cli_req_valid = '1;
    cli_req_write = '1;
    settle();
    chk("t5_rr_ptr2", {28'd0, cli_req_ready}, 32'b0100);
    cyc();

    // Three reads outstanding (grants 3,0,1), then asynchronous reset
    cli_req_write = '0;
    settle();
    chk("t6_grant3", {28'd0, cli_req_ready}, 32'b1000);
    cyc();
    settle();
    chk("t6_grant0", {28'd0, cli_req_ready}, 32'b0001);
    cyc();
    settle();
    chk("t6_grant1", {28'd0, cli_req_ready}, 32'b0010);
    cyc();
    cli_req_valid = '0;
    settle();
    chk("t6_count3", {29'd0, reads_outstanding}, 32'd3);
    cli_req_valid        = '1;
    dma_rdy_readresponse = 1'b1;
    #2;
    RST_N = 1'b0;
    #1;
    chk("t6_rst_ready", {28'd0, cli_req_ready}, 32'd0);
    chk("t6_rst_en_rr", {31'd0, dma_en_readrequest}, 32'd0);
    chk("t6_rst_valid", {28'd0, cli_rsp_valid}, 32'd0);
    chk("t6_rst_en_rsp", {31'd0, dma_en_readresponse}, 32'd0);
    chk("t6_rst_count", {29'd0, reads_outstanding}, 32'd0);
    dma_rdy_readresponse = 1'b0;
    cli_req_write = '1;
    cyc();
    RST_N = 1'b1;
    settle();
    chk("t6_rr_ptr0", {28'd0, cli_req_ready}, 32'b0001);
    chk("t6_post_count", {29'd0, reads_outstanding}, 32'd0);
    cyc();

    // Simultaneous push and pop keeps the count unchanged
    cli_req_write = '0;
    cli_req_valid = 4'b0001;
    settle();
    chk("pp_grant0", {28'd0, cli_req_ready}, 32'b0001);
    cyc();
    cli_req_valid         = 4'b0010;
    dma_rdy_readresponse  = 1'b1;
    dma_readresponse_data = 32'h0000_0077;
    settle();
    chk("pp_grant1", {28'd0, cli_req_ready}, 32'b0010);
    chk("pp_rsp0", {28'd0, cli_rsp_valid}, 32'b0001);
    chk("pp_en", {31'd0, dma_en_readresponse}, 32'd1);
    cyc();
    cli_req_valid = '0;
    settle();
    chk("pp_count", {29'd0, reads_outstanding}, 32'd1);
    chk("pp_rsp1", {28'd0, cli_rsp_valid}, 32'b0010);
    cyc();
    dma_rdy_readresponse = 1'b0;
    settle();
    chk("pp_count0", {29'd0, reads_outstanding}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
